sap1_prog_loader: RTL and testbench
===================================

// Module: sap1_prog_loader
// PURPOSE
//   Upstream stage of the SAP-1 core: owns the 16x8 program/data RAM and fills it from the
//   pins (byte + strobe) before releasing the CPU. Synchronises the external strobe, writes
//   16 bytes sequentially, then verifies a trailing checksum byte. Holds the CPU in reset
//   (cpu_rst) until a load verifies. Serves the CPU's combinational read port (mar -> mem_out).
// PARAMETERS
//   ADDR_W       4   RAM address width; DEPTH = 2**ADDR_W words
//   DATA_W       8   RAM word / input byte width
//   SYNC_STAGES  2   flops in the strobe/data synchroniser (>=2)
// PORTS
//   clk        in   1       clock
//   rst        in   1       reset rst, synchronous, active-high
//   load_en    in   1       host request: high = load session active (already synchronous to clk)
//   data_in    in   DATA_W  byte from pins; stable from before data_stb rises until after it falls
//   data_stb   in   1       asynchronous byte strobe from pins; rising edge = one byte
//   rd_addr    in   ADDR_W  CPU read address (MAR)
//   rd_data    out  DATA_W  mem[rd_addr], combinational
//   cpu_rst    out  1       reset to SAP-1 core, active-high
//   load_addr  out  ADDR_W  next RAM address to be written
//   load_done  out  1       high while in RUN (checksum passed)
//   load_err   out  1       high while in ERR (checksum failed)
// BEHAVIOUR
//   Reset: state=IDLE, cpu_rst=1, load_done=0, load_err=0, load_addr=0, sum=0, sync flops=0.
//     The RAM array has no reset; rd_data is undefined until written. Contents survive rst.
//   Sync: data_stb and data_in pass through SYNC_STAGES flops plus one edge flop;
//     stb_edge = s[last] & ~edge_q. With SYNC_STAGES=2 the write commits on the 3rd clk edge,
//     counting the first edge that samples data_stb=1 as edge 1. Data uses the same-depth delay.
//     A strobe held high any number of cycles produces exactly one stb_edge.
//   FSM (registered; one transition per cycle):
//     IDLE : cpu_rst=1. load_en=1 -> LOAD, load_addr<=0, sum<=0.
//     LOAD : on stb_edge: mem[load_addr]<=byte, sum<=sum+byte (mod 2**DATA_W), load_addr++.
//            Write to address DEPTH-1 -> CHECK (load_addr wraps to 0).
//            load_en=0 -> IDLE (abort; written words kept; load_addr<=0), abort wins over stb_edge.
//     CHECK: on stb_edge: (sum+byte)==0 -> RUN else ERR. Checksum byte is not stored.
//            load_en=0 -> IDLE.
//     RUN  : cpu_rst=0, load_done=1. load_en=1 -> LOAD (cpu_rst=1 from the next cycle).
//            stb_edge ignored.
//     ERR  : cpu_rst=1, load_err=1. load_en=1 -> LOAD (load_err clears). stb_edge ignored.
//   Outputs cpu_rst/load_done/load_err are registered (decoded from state register only).
//   rst asserted mid-load -> IDLE next edge, pending synchronised strobe discarded.
//   No RAM write ever occurs outside LOAD; reads during LOAD return current array contents.
// STRUCTURE
//   Shared package sap1_pkg: ADDR_W/DATA_W defaults, loader state encoding
//     (IDLE=0, LOAD=1, CHECK=2, RUN=3, ERR=4; 3 bits), shared with the SAP-1 core.
//   Sub-module sap1_sync_edge: N-stage synchroniser + rising-edge pulse, parameterised width,
//     instanced once for {data_stb, data_in}.
//   Top: FSM, address counter, checksum accumulator, RAM array with async read.
// TESTING
//   1 rst=1 for 2 cycles -> cpu_rst=1, load_done=0, load_err=0, load_addr=0, state IDLE.
//   2 load_en=1, strobe bytes 0x01..0x10 then checksum 0x78 -> load_done=1, cpu_rst=0;
//     rd_addr=5 -> rd_data=0x06; rd_addr=15 -> 0x10.
//   3 same 16 bytes, checksum 0x00 -> load_err=1, cpu_rst=1; load_en toggled 0->1 -> LOAD,
//     load_err=0, load_addr=0.
//   4 load_en drops after 5 bytes (0xA0..0xA4) -> IDLE, load_addr=0, mem[0..4]=0xA0..0xA4,
//     mem[5] unchanged.
//   5 data_stb held high 20 cycles with data_in=0x3C -> exactly one write, load_addr 0->1,
//     write visible on 3rd edge after first sampled high.
//   6 rst pulsed after 8 bytes, then full valid load -> starts at address 0, ends in RUN.

Source files
------------

// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: default widths and the program-loader state encoding.
// The state encoding is also consumed by the SAP-1 core.
package sap1_pkg;

  localparam int DEF_ADDR_W      = 4;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    LD_IDLE  = 3'd0,
    LD_LOAD  = 3'd1,
    LD_CHECK = 3'd2,
    LD_RUN   = 3'd3,
    LD_ERR   = 3'd4
  } loader_state_e;

  // Output flags {cpu_rst, load_done, load_err} implied by each loader state.
  function automatic logic [2:0] loader_flags(input loader_state_e s);
    logic [2:0] f;
    f = 3'b100;
    case (s)
      LD_RUN:  f = 3'b010;
      LD_ERR:  f = 3'b101;
      default: f = 3'b100;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/sap1_sync_edge.sv
// Multi-stage synchroniser for a bus whose MSB is a strobe; emits a one-cycle
// pulse on each synchronised rising edge of that strobe alongside the delayed data.
module sap1_sync_edge
  import sap1_pkg::*;
#(
  parameter int WIDTH  = DEF_DATA_W + 1,
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-2:0] o_q,
  output logic             o_rise
);

  logic [WIDTH-1:0] r_sync [STAGES];
  logic             r_edge_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) r_sync[i] <= '0;
      r_edge_q <= 1'b0;
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_edge_q <= r_sync[STAGES-1][WIDTH-1];
    end
  end

  assign o_q    = r_sync[STAGES-1][WIDTH-2:0];
  assign o_rise = r_sync[STAGES-1][WIDTH-1] & ~r_edge_q;

endmodule

// File: rtl/sap1_prog_loader.sv
// SAP-1 program loader: fills the program RAM from strobed pin bytes, verifies a
// trailing checksum and holds the CPU in reset until a load verifies.
module sap1_prog_loader
  import sap1_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load_en,
  input  logic [DATA_W-1:0] i_data_in,
  input  logic              i_data_stb,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_cpu_rst,
  output logic [ADDR_W-1:0] o_load_addr,
  output logic              o_load_done,
  output logic              o_load_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] w_byte;
  logic              w_stb_edge;
  logic              w_wr_en;
  logic [DATA_W-1:0] w_sum_next;
  loader_state_e     w_verdict;

  loader_state_e     r_state;
  logic [ADDR_W-1:0] r_load_addr;
  logic [DATA_W-1:0] r_sum;
  logic              r_cpu_rst;
  logic              r_load_done;
  logic              r_load_err;
  logic [DATA_W-1:0] r_mem [DEPTH];

  sap1_sync_edge #(
    .WIDTH  (DATA_W + 1),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .i_d    ({i_data_stb, i_data_in}),
    .o_q    (w_byte),
    .o_rise (w_stb_edge)
  );

  assign w_wr_en    = !rst && (r_state == LD_LOAD) && i_load_en && w_stb_edge;
  assign w_sum_next = r_sum + w_byte;
  assign w_verdict  = (w_sum_next == '0) ? LD_RUN : LD_ERR;

  // Dropping load_en aborts a session and takes priority over a coincident strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= LD_IDLE;
      {r_cpu_rst, r_load_done, r_load_err} <= loader_flags(LD_IDLE);
      r_load_addr <= '0;
      r_sum       <= '0;
    end else begin
      case (r_state)
        LD_IDLE: begin
          if (i_load_en) begin
            r_state     <= LD_LOAD;
            {r_cpu_rst, r_load_done, r_load_err} <= loader_flags(LD_LOAD);
            r_load_addr <= '0;
            r_sum       <= '0;
          end
        end
        LD_LOAD: begin
          if (!i_load_en) begin
            r_state     <= LD_IDLE;
            {r_cpu_rst, r_load_done, r_load_err} <= loader_flags(LD_IDLE);
            r_load_addr <= '0;
          end else if (w_stb_edge) begin
            r_sum       <= w_sum_next;
            r_load_addr <= r_load_addr + 1'b1;
            if (r_load_addr == LAST_ADDR) begin
              r_state <= LD_CHECK;
              {r_cpu_rst, r_load_done, r_load_err} <= loader_flags(LD_CHECK);
            end
          end
        end
        LD_CHECK: begin
          if (!i_load_en) begin
            r_state     <= LD_IDLE;
            {r_cpu_rst, r_load_done, r_load_err} <= loader_flags(LD_IDLE);
            r_load_addr <= '0;
          end else if (w_stb_edge) begin
            r_state <= w_verdict;
            {r_cpu_rst, r_load_done, r_load_err} <= loader_flags(w_verdict);
          end
        end
        LD_RUN, LD_ERR: begin
          if (i_load_en) begin
            r_state     <= LD_LOAD;
            {r_cpu_rst, r_load_done, r_load_err} <= loader_flags(LD_LOAD);
            r_load_addr <= '0;
            r_sum       <= '0;
          end
        end
        default: begin
          r_state     <= LD_IDLE;
          {r_cpu_rst, r_load_done, r_load_err} <= loader_flags(LD_IDLE);
          r_load_addr <= '0;
          r_sum       <= '0;
        end
      endcase
    end
  end

  // The array has no reset so a program survives rst.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_load_addr] <= w_byte;
  end

  assign o_rd_data   = r_mem[i_rd_addr];
  assign o_cpu_rst   = r_cpu_rst;
  assign o_load_addr = r_load_addr;
  assign o_load_done = r_load_done;
  assign o_load_err  = r_load_err;

endmodule

// File: tb/tb_sap1_prog_loader.sv
// Self-checking bench for sap1_prog_loader against a session-level model of the
// loader (byte count, running sum, verdict and RAM image).
module tb_sap1_prog_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       loadEn;
  logic [7:0] dataIn;
  logic       dataStb;
  logic [3:0] rdAddr;
  logic [7:0] rdData;
  logic       cpuRst;
  logic [3:0] loadAddr;
  logic       loadDone;
  logic       loadErr;

  sap1_prog_loader dut (
    .clk         (clk),
    .rst         (rst),
    .i_load_en   (loadEn),
    .i_data_in   (dataIn),
    .i_data_stb  (dataStb),
    .i_rd_addr   (rdAddr),
    .o_rd_data   (rdData),
    .o_cpu_rst   (cpuRst),
    .o_load_addr (loadAddr),
    .o_load_done (loadDone),
    .o_load_err  (loadErr)
  );

  always #5 clk = ~clk;

  int compareCount  = 0;
  int mismatchCount = 0;

  // Model: a session collects 16 bytes then one checksum byte; verdict 1=pass 2=fail.
  logic [7:0] modelMem [16];
  bit         modelValid [16];
  bit         modelSession;
  int         modelCount;
  logic [7:0] modelSum;
  int         modelVerdict;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compareCount++;
    if (got !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic modelByte(input logic [7:0] b);
    logic [7:0] total;
    if (modelSession) begin
      if (modelCount < 16) begin
        modelMem[modelCount]   = b;
        modelValid[modelCount] = 1'b1;
        modelSum   = modelSum + b;
        modelCount = modelCount + 1;
      end else begin
        total        = modelSum + b;
        modelVerdict = (total == 8'd0) ? 1 : 2;
        modelSession = 1'b0;
      end
    end
  endtask

  task automatic checkFlags(input string tag);
    logic [3:0] expAddr;
    expAddr = (modelSession && modelCount < 16) ? 4'(modelCount) : 4'd0;
    checkOutput({tag, ".cpu_rst"},   32'(cpuRst),   32'(modelVerdict != 1));
    checkOutput({tag, ".load_done"}, 32'(loadDone), 32'(modelVerdict == 1));
    checkOutput({tag, ".load_err"},  32'(loadErr),  32'(modelVerdict == 2));
    checkOutput({tag, ".load_addr"}, 32'(loadAddr), 32'(expAddr));
  endtask

  task automatic checkMem(input string tag);
    for (int a = 0; a < 16; a++) begin
      if (modelValid[a]) begin
        rdAddr = 4'(a);
        #1;
        checkOutput($sformatf("%s.mem[%0d]", tag, a), 32'(rdData), 32'(modelMem[a]));
      end
    end
  endtask

  // Sends one byte; returns #1 after the edge where the write/verdict commits.
  task automatic applyStimulus(input logic [7:0] b, input bit releaseLoad);
    @(negedge clk);
    dataIn = b;
    @(negedge clk);
    dataStb = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    modelByte(b);
    if (releaseLoad) loadEn = 1'b0;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    dataStb = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic startLoad(input string tag);
    @(negedge clk);
    loadEn = 1'b1;
    @(posedge clk);
    #1;
    modelSession = 1'b1;
    modelCount   = 0;
    modelSum     = 8'd0;
    modelVerdict = 0;
    checkFlags(tag);
  endtask

  task automatic abortLoad(input string tag);
    @(negedge clk);
    loadEn = 1'b0;
    @(posedge clk);
    #1;
    modelSession = 1'b0;
    modelVerdict = 0;
    checkFlags(tag);
  endtask

  task automatic fullLoad(input string tag, input bit goodSum, input bit randomBytes);
    logic [7:0] b;
    logic [7:0] sum;
    sum = 8'd0;
    startLoad({tag, ".start"});
    for (int i = 0; i < 16; i++) begin
      b = randomBytes ? 8'($urandom_range(0, 255)) : 8'(i + 1);
      sum = sum + b;
      applyStimulus(b, 1'b0);
      if (i == 4 || i == 15) checkFlags($sformatf("%s.byte%0d", tag, i));
    end
    b = 8'd0 - sum;
    if (!goodSum) b = b + 8'($urandom_range(1, 255));
    applyStimulus(b, 1'b1);
    checkFlags({tag, ".verdict"});
    checkMem(tag);
  endtask

  initial begin
    rst = 1'b1; loadEn = 1'b0; dataIn = 8'd0; dataStb = 1'b0; rdAddr = 4'd0;
    modelSession = 1'b0; modelCount = 0; modelSum = 8'd0; modelVerdict = 0;
    for (int a = 0; a < 16; a++) modelValid[a] = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkFlags("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkFlags("idle");

    // Known program 0x01..0x10 with checksum 0x78 verifies.
    fullLoad("good", 1'b1, 1'b0);
    rdAddr = 4'd5;  #1; checkOutput("rd5",  32'(rdData), 32'h06);
    rdAddr = 4'd15; #1; checkOutput("rd15", 32'(rdData), 32'h10);
    repeat (4) @(posedge clk);
    #1;
    checkFlags("run.hold");

    // Same bytes with a zero checksum byte must fail.
    startLoad("bad.start");
    for (int i = 0; i < 16; i++) applyStimulus(8'(i + 1), 1'b0);
    applyStimulus(8'h00, 1'b1);
    checkFlags("bad.verdict");
    startLoad("err.reload");

    // Abort after five bytes keeps what was written.
    for (int i = 0; i < 5; i++) applyStimulus(8'(8'hA0 + i), 1'b0);
    checkFlags("abort.pre");
    abortLoad("abort");
    checkMem("abort");

    // A long strobe produces exactly one write, committed on the third edge.
    startLoad("long.start");
    rdAddr = 4'd0;
    @(negedge clk);
    dataIn = 8'h3C;
    @(negedge clk);
    dataStb = 1'b1;
    @(posedge clk); #1;
    checkOutput("long.edge1.addr", 32'(loadAddr), 32'd0);
    @(posedge clk); #1;
    checkOutput("long.edge2.addr", 32'(loadAddr), 32'd0);
    checkOutput("long.edge2.mem0", 32'(rdData), 32'hA0);
    @(posedge clk); #1;
    modelByte(8'h3C);
    checkOutput("long.edge3.addr", 32'(loadAddr), 32'd1);
    checkOutput("long.edge3.mem0", 32'(rdData), 32'h3C);
    repeat (17) @(posedge clk);
    #1;
    checkFlags("long.held");
    @(negedge clk);
    dataStb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkFlags("long.released");
    abortLoad("long.abort");

    // Reset mid-load, then a full valid load restarts from address 0.
    startLoad("rst.start");
    for (int i = 0; i < 8; i++) applyStimulus(8'($urandom_range(0, 255)), 1'b0);
    checkFlags("rst.pre");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    modelSession = 1'b0;
    modelVerdict = 0;
    checkFlags("rst.idle");
    @(negedge clk);
    rst = 1'b0;
    loadEn = 1'b0;
    fullLoad("afterrst", 1'b1, 1'b1);

    for (int k = 0; k < 4; k++) fullLoad($sformatf("rand%0d", k), ($urandom_range(0, 1) == 1), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
